sram_rw_port_ctrl: RTL and testbench
====================================

Name: sram_rw_port_ctrl

Overview:
- Requester-side controller for a single-port, synchronous-read SRAM macro: 64x6, one RW port, one mask bit covering all 6 bits.
- Accepts independent write and read request streams (valid/ready) and arbitrates them onto the single RW port.
- Clears the whole array after reset and returns read data on a backpressurable response channel.
- Sits between cache/predictor control logic and the memory macro; the macro clock is tied to clock at the parent.

Parameters:
- DEPTH, 64, number of SRAM entries.
- ADDR_W, 6, address width (log2 DEPTH).
- WIDTH, 6, data width.
- INIT_ON_RESET, 1, when 1 the controller sweeps the array with INIT_VALUE after reset.
- INIT_VALUE, 0, WIDTH-bit value written during the sweep.

Ports:
- clock  in  1  block clock.
- reset_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the sweep is complete; stays high until the next reset.
- w_valid  in  1  write request valid.
- w_ready  out  1  write request accepted.
- w_addr  in  ADDR_W  write address.
- w_data  in  WIDTH  write data.
- w_mask  in  1  write mask.
- r_req_valid  in  1  read request valid.
- r_req_ready  out  1  read request accepted.
- r_req_addr  in  ADDR_W  read address.
- r_resp_valid  out  1  read data valid.
- r_resp_ready  in  1  consumer accepts read data.
- r_resp_data  out  WIDTH  read data.
- sram_addr  out  ADDR_W  to macro address.
- sram_en  out  1  to macro enable.
- sram_wmode  out  1  to macro write mode; 1 = write.
- sram_wmask  out  1  to macro write mask.
- sram_wdata  out  WIDTH  to macro write data.
- sram_rdata  in  WIDTH  from macro; valid the cycle after a read enable only.

Behaviour:
- Reset (asynchronous, active-low) values:
  - State RST; init counter 0; response slot empty.
  - All outputs 0: init_done, w_ready, r_req_ready, r_resp_valid, r_resp_data, sram_en, sram_wmode, sram_wmask, sram_addr, sram_wdata.
- FSM states:
  - RST: one cycle with sram_en=0. Goes to INIT if INIT_ON_RESET=1, otherwise to RUN.
  - INIT: every cycle drives sram_en=1, wmode=1, wmask=1, addr=counter, wdata=INIT_VALUE, then increments the counter. When the counter reaches DEPTH-1 and that write is issued, goes to RUN. Sweep length is DEPTH cycles. w_ready and r_req_ready are 0 throughout.
  - RUN: init_done=1.
- Arbitration in RUN (combinational port drive):
  - Write has priority: w_ready = 1. When w_valid=1, drive en=1, wmode=1, wmask=w_mask, addr=w_addr, wdata=w_data.
  - r_req_ready = !w_valid & (!r_resp_valid | r_resp_ready). On read fire, drive en=1, wmode=0, addr=r_req_addr.
  - Neither request active: sram_en=0 and the other sram outputs hold 0.
- Read latency:
  - A read fired in cycle t sets the data phase for t+1. In t+1, r_resp_valid=1 and r_resp_data=sram_rdata (pass-through).
  - If r_resp_ready=0 in t+1, sram_rdata is captured into the hold register at the end of t+1. From t+2, data comes from the hold register until the handshake completes.
  - Macro rdata is garbage once a non-read cycle follows, so the controller never re-samples sram_rdata after t+1.
- Throughput: back-to-back reads at 1 per cycle when the consumer is always ready. Only one response is ever outstanding or held.
- Write in the same cycle as a data phase: the captured or passed data is the pre-write content, because the macro write takes effect at the clock edge.
- Write and read to the same address together: the read stalls (r_req_ready=0). The next cycle's read returns the new data.
- w_mask=0 write: accepted, the port is enabled, and the array is unchanged.
- Reset asserted mid-sweep or mid-response: the pending response is dropped, the FSM returns to RST, and the sweep restarts from address 0.
- Counter is ADDR_W+1 bits so the terminal compare is not defeated by wrap-around.

Decomposition:
- Shared package sram_ctrl_pkg holds the state enum {RST, INIT, RUN} and the default DEPTH/WIDTH constants.
- One sub-module, sram_resp_buf: a 1-entry response slot with pass-through-or-hold logic. Inputs are data_phase and sram_rdata; outputs are valid/ready/data.

Test Plan:
- Reset release, INIT_ON_RESET=1 -> 1 RST cycle, then writes of value 0 to addresses 0..63 on consecutive cycles; init_done rises the cycle after the addr 63 write; ready signals are 0 throughout.
- Write addr 5 data 0x2A mask 1; next cycle read addr 5 with ready=1 -> r_resp_valid one cycle after the read fire with data 0x2A.
- Read addr 5, hold r_resp_ready=0 for 4 cycles while writing 0x11 to addr 5 -> r_resp_data stays 0x2A, r_req_ready=0; after ready=1, a new read returns 0x11.
- w_valid and r_req_valid both 1 for addr 9 (write 0x3F) -> write issued first with r_req_ready=0; read fires next cycle and returns 0x3F.
- Write addr 7 with w_mask=0 after the init sweep -> a read of addr 7 returns INIT_VALUE 0.
- Assert reset_n=0 at sweep address 30 -> all outputs 0 immediately; after release the sweep restarts at addr 0 and init_done takes 65 cycles again.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the SRAM read/write port controller.
package sram_ctrl_pkg;

    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 6;
    localparam int WIDTH_DEF  = 6;

    typedef enum logic [1:0] {
        RST,
        INIT,
        RUN
    } ctrl_state_e;

endpackage

// File: rtl/sram_resp_buf.sv
// One-entry read response slot: passes macro rdata through during the data phase,
// holds it when the consumer stalls, and frees only on a completed handshake.
module sram_resp_buf
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             data_phase,
    input  logic [WIDTH-1:0] sram_rdata,
    input  logic             resp_ready,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             slot_ready
);

    logic             held_q, held_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;

    // NOTE: every variable gets its current value as a default first, so no branch can infer a latch.
    always_comb begin
        held_d      = held_q;
        hold_data_d = hold_data_q;
        if (data_phase && !resp_ready) begin
            held_d      = 1'b1;
            hold_data_d = sram_rdata;
        end else if (held_q && resp_ready) begin
            held_d = 1'b0;
        end
    end

    // NOTE: the hold register is reset only so r_resp_data reads 0 out of reset; the macro
    // array itself is never reset here, the init sweep clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            held_q      <= held_d;
            hold_data_q <= hold_data_d;
        end
    end

    // rdata is only trustworthy in the data phase; afterwards the captured copy is used.
    assign resp_valid = data_phase | held_q;
    assign resp_data  = data_phase ? sram_rdata : hold_data_q;
    assign slot_ready = !resp_valid || resp_ready;

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Arbitrates independent write and read request streams onto a single-port,
// synchronous-read SRAM macro, clearing the array after reset.
module sram_rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                DEPTH         = DEPTH_DEF,
    parameter int                ADDR_W        = ADDR_W_DEF,
    parameter int                WIDTH         = WIDTH_DEF,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [WIDTH-1:0]  INIT_VALUE    = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic              w_mask,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    input  logic              r_resp_ready,
    output logic [WIDTH-1:0]  r_resp_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic              sram_wmask,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata
);

    // One extra counter bit keeps the terminal compare safe from wrap-around.
    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_phase_q, data_phase_d;
    logic             slot_ready;
    logic             read_fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RST;
            cnt_q        <= '0;
            data_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_phase_q <= data_phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RST: begin
                cnt_d   = '0;
                state_d = (INIT_ON_RESET != 0) ? INIT : RUN;
            end
            INIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = RST;
        endcase
    end

    always_comb begin
        init_done   = 1'b0;
        w_ready     = 1'b0;
        r_req_ready = 1'b0;
        sram_en     = 1'b0;
        sram_wmode  = 1'b0;
        sram_wmask  = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        unique case (state_q)
            INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = 1'b1;
                sram_addr  = cnt_q[ADDR_W-1:0];
                sram_wdata = INIT_VALUE;
            end
            RUN: begin
                init_done = 1'b1;
                w_ready   = 1'b1;
                // Any pending write wins the port, so a same-cycle read simply waits a cycle.
                r_req_ready = !w_valid && slot_ready;
                if (w_valid) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_wmask = w_mask;
                    sram_addr  = w_addr;
                    sram_wdata = w_data;
                end else if (r_req_valid && r_req_ready) begin
                    sram_en   = 1'b1;
                    sram_addr = r_req_addr;
                end
            end
            default: ;
        endcase
    end

    assign read_fire    = r_req_valid && r_req_ready;
    assign data_phase_d = read_fire;

    sram_resp_buf #(
        .WIDTH(WIDTH)
    ) u_resp_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_phase (data_phase_q),
        .sram_rdata (sram_rdata),
        .resp_ready (r_resp_ready),
        .resp_valid (r_resp_valid),
        .resp_data  (r_resp_data),
        .slot_ready (slot_ready)
    );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench: behavioural SRAM macro plus a transaction-level model of the
// controller, compared against the DUT every cycle, with directed and random traffic.
module tb_sram_rw_port_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int W     = 6;
    localparam logic [W-1:0] INIT_VALUE = '0;
    localparam int SWEEP_END = DEPTH + 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          init_done;
    logic          w_valid = 1'b0, w_ready, w_mask = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [W-1:0]  w_data = '0;
    logic          r_req_valid = 1'b0, r_req_ready;
    logic [AW-1:0] r_req_addr = '0;
    logic          r_resp_valid, r_resp_ready = 1'b0;
    logic [W-1:0]  r_resp_data;
    logic [AW-1:0] sram_addr;
    logic          sram_en, sram_wmode, sram_wmask;
    logic [W-1:0]  sram_wdata, sram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sram_rw_port_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(AW), .WIDTH(W), .INIT_ON_RESET(1), .INIT_VALUE(INIT_VALUE)
    ) dut (
        .clock(clock), .reset_n(reset_n), .init_done(init_done),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
        .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural macro: synchronous read, rdata is junk unless the previous cycle was a read.
    logic [W-1:0] macro_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) macro_mem[i] = W'($urandom);
        sram_rdata = W'($urandom);
    end
    always @(posedge clock) begin
        if (sram_en && sram_wmode && sram_wmask) macro_mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_wmode) sram_rdata <= macro_mem[sram_addr];
        else                        sram_rdata <= W'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k = cycles since reset release; one outstanding response slot.
    int           k = 0;
    bit           pend = 1'b0;
    logic [W-1:0] pend_data = '0;
    logic [W-1:0] ref_mem [DEPTH];
    bit           m_rr;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k    = 0;
            pend = 1'b0;
        end else begin
            if (k >= 1 && k <= DEPTH) begin
                ref_mem[k-1] = INIT_VALUE;
            end else if (k >= SWEEP_END) begin
                m_rr = !w_valid && (!pend || r_resp_ready);
                if (pend && r_resp_ready) pend = 1'b0;
                if (r_req_valid && m_rr) begin
                    pend      = 1'b1;
                    pend_data = ref_mem[r_req_addr];
                end
                if (w_valid && w_mask) ref_mem[w_addr] = w_data;
            end
            if (k < 1000) k++;
        end
    end

    always @(negedge clock) begin
        if (!reset_n || k == 0) begin
            check("rst_init_done", init_done, 0);
            check("rst_w_ready", w_ready, 0);
            check("rst_r_req_ready", r_req_ready, 0);
            check("rst_resp_valid", r_resp_valid, 0);
            check("rst_resp_data", r_resp_data, 0);
            check("rst_sram", {sram_en, sram_wmode, sram_wmask, sram_addr, sram_wdata}, 0);
        end else if (k <= DEPTH) begin
            check("init_done_low", init_done, 0);
            check("init_readies", {w_ready, r_req_ready}, 0);
            check("init_resp_valid", r_resp_valid, 0);
            check("init_ctl", {sram_en, sram_wmode, sram_wmask}, 3'b111);
            check("init_addr", sram_addr, k - 1);
            check("init_wdata", sram_wdata, INIT_VALUE);
        end else begin
            bit rr;
            rr = !w_valid && (!pend || r_resp_ready);
            check("run_init_done", init_done, 1);
            check("run_w_ready", w_ready, 1);
            check("run_r_req_ready", r_req_ready, rr);
            check("run_resp_valid", r_resp_valid, pend);
            if (pend) check("run_resp_data", r_resp_data, pend_data);
            if (w_valid) begin
                check("run_wr_port", {sram_en, sram_wmode, sram_wmask, sram_addr, sram_wdata},
                      {2'b11, w_mask, w_addr, w_data});
            end else if (r_req_valid && rr) begin
                check("run_rd_port", {sram_en, sram_wmode, sram_addr}, {2'b10, r_req_addr});
            end else begin
                check("run_idle_port", {sram_en, sram_wmode, sram_wmask, sram_addr, sram_wdata}, 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        w_valid = 1'b0; w_mask = 1'b0; w_addr = '0; w_data = '0;
        r_req_valid = 1'b0; r_req_addr = '0;
    endtask

    task automatic wait_init();
        int cnt = 0;
        while (!init_done && cnt < 200) begin
            cyc();
            cnt++;
            if (cnt == 1)  check("sweep_first_addr", {sram_en, sram_addr}, {1'b1, 6'd0});
            if (cnt == 64) check("sweep_last_addr", {sram_en, sram_addr}, {1'b1, 6'd63});
            if (cnt == 64) check("sweep_done_not_yet", init_done, 0);
        end
        check("init_cycles", cnt, 65);
    endtask

    initial begin
        // Reset and first sweep.
        #1 reset_n = 1'b0;
        repeat (3) cyc();
        check("reset_outputs", {init_done, w_ready, r_req_ready, r_resp_valid, sram_en}, 0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        wait_init();

        // Write 5 <- 0x2A, then read it back.
        w_valid = 1'b1; w_addr = 6'd5; w_data = 6'h2A; w_mask = 1'b1;
        cyc();
        w_valid = 1'b0; r_req_valid = 1'b1; r_req_addr = 6'd5; r_resp_ready = 1'b1;
        @(negedge clock);
        check("rd5_ready", r_req_ready, 1);
        cyc();
        r_req_valid = 1'b0;
        @(negedge clock);
        check("rd5_valid", r_resp_valid, 1);
        check("rd5_data", r_resp_data, 6'h2A);

        // Stalled response while overwriting the same address.
        cyc();
        r_req_valid = 1'b1; r_req_addr = 6'd5; r_resp_ready = 1'b0;
        cyc();
        w_valid = 1'b1; w_addr = 6'd5; w_data = 6'h11; w_mask = 1'b1;
        @(negedge clock);
        check("hold_data_wr", r_resp_data, 6'h2A);
        check("hold_rrdy_wr", r_req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            w_valid = 1'b0;
            @(negedge clock);
            check("hold_valid", r_resp_valid, 1);
            check("hold_data", r_resp_data, 6'h2A);
            check("hold_rrdy", r_req_ready, 0);
        end
        cyc();
        r_resp_ready = 1'b1;
        @(negedge clock);
        check("release_rrdy", r_req_ready, 1);
        cyc();
        r_req_valid = 1'b0;
        @(negedge clock);
        check("reread_data", r_resp_data, 6'h11);

        // Simultaneous write and read of address 9.
        cyc();
        w_valid = 1'b1; w_addr = 6'd9; w_data = 6'h3F; w_mask = 1'b1;
        r_req_valid = 1'b1; r_req_addr = 6'd9;
        @(negedge clock);
        check("collide_rrdy", r_req_ready, 0);
        check("collide_wmode", sram_wmode, 1);
        cyc();
        w_valid = 1'b0;
        @(negedge clock);
        check("collide_rd_fire", r_req_ready, 1);
        cyc();
        r_req_valid = 1'b0;
        @(negedge clock);
        check("collide_data", r_resp_data, 6'h3F);

        // Masked-off write leaves the init value in place.
        cyc();
        w_valid = 1'b1; w_addr = 6'd7; w_data = 6'h15; w_mask = 1'b0;
        @(negedge clock);
        check("mask0_port", {sram_en, sram_wmask}, 2'b10);
        cyc();
        w_valid = 1'b0; r_req_valid = 1'b1; r_req_addr = 6'd7;
        cyc();
        r_req_valid = 1'b0;
        @(negedge clock);
        check("mask0_data", r_resp_data, INIT_VALUE);

        // Random traffic over a small address window to force collisions.
        for (int i = 0; i < 1500; i++) begin
            cyc();
            w_valid      = ($urandom_range(0, 99) < 30);
            w_addr       = AW'($urandom_range(0, 15));
            w_data       = W'($urandom);
            w_mask       = ($urandom_range(0, 99) < 80);
            r_req_valid  = ($urandom_range(0, 99) < 60);
            r_req_addr   = AW'($urandom_range(0, 15));
            r_resp_ready = ($urandom_range(0, 99) < 60);
        end

        // Reset in the middle of a response, then again mid-sweep at address 30.
        cyc();
        #2 reset_n = 1'b0;
        #1 check("midresp_reset", {r_resp_valid, r_resp_data, sram_en}, 0);
        idle_inputs();
        r_resp_ready = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
        begin
            int cnt = 0;
            bit found = 1'b0;
            while (!found && cnt < 100) begin
                cyc();
                cnt++;
                if (sram_en && sram_addr == 6'd30) found = 1'b1;
            end
            check("reach_addr30", found, 1);
        end
        #1 reset_n = 1'b0;
        #1 check("midsweep_outputs",
                 {init_done, w_ready, r_req_ready, r_resp_valid, sram_en, sram_wmode,
                  sram_wmask, sram_addr, sram_wdata, r_resp_data}, 0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        wait_init();

        for (int i = 0; i < 300; i++) begin
            cyc();
            w_valid      = ($urandom_range(0, 99) < 25);
            w_addr       = AW'($urandom);
            w_data       = W'($urandom);
            w_mask       = ($urandom_range(0, 99) < 70);
            r_req_valid  = ($urandom_range(0, 99) < 70);
            r_req_addr   = AW'($urandom);
            r_resp_ready = ($urandom_range(0, 99) < 50);
        end
        cyc();
        idle_inputs();
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
